// File: rtl/x25519_mult_sequencer.sv
// ---------------------------------------------------------------------------
// x25519_mult_sequencer
//
// Purpose:
//   Sequences one Curve25519 field multiply through an external column-pass
//   pipeline. It issues 32 column passes, collects the 32 column sums, and
//   then runs the two-round NaCl carry squeeze, one limb per cycle. The
//   squeezed product is published on o_result with a one-cycle o_done pulse.
//
// Ports:
//   i_clk, i_rst     clock; asynchronous active-high reset
//   i_start          one-cycle request, accepted only in IDLE
//   i_a_in, i_b_in   operands, 32 byte limbs, limb j has weight 2^(8j)
//   o_busy           operation or post-reset drain in progress
//   o_done           one-cycle pulse, o_result is valid in that cycle
//   o_result         squeezed product, held until the next done
//   o_pass_en        column pass issue strobe
//   o_pass_i         column index of the current pass
//   o_pass_a         latched a
//   o_pass_b         b rearranged for column o_pass_i
//   i_pass_valid     column sum valid, returned by the pass pipeline
//   i_pass_out       column sum, returned by the pass pipeline
// ---------------------------------------------------------------------------
typedef struct packed {
   logic [31:0][7:0] blocks;
} bignum_t;

module x25519_mult_sequencer #(
   parameter int PASS_LATENCY = 5   // must be at least 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  bignum_t     i_a_in,
   input  bignum_t     i_b_in,
   output logic        o_busy,
   output logic        o_done,
   output bignum_t     o_result,
   output logic        o_pass_en,
   output logic [4:0]  o_pass_i,
   output bignum_t     o_pass_a,
   output bignum_t     o_pass_b,
   input  logic        i_pass_valid,
   input  logic [31:0] i_pass_out
);

   typedef enum logic [2:0] {
      S_DRAIN, S_IDLE, S_ISSUE, S_COLLECT, S_SQ1, S_SQ2, S_DONE
   } state_t;

   state_t      r_state;
   logic [7:0]  r_drain_cnt;
   logic [5:0]  r_coll_cnt;
   logic [4:0]  r_sq_j;
   logic [32:0] r_carry;
   logic [31:0] r_w [32];
   bignum_t     r_a;
   bignum_t     r_b;
   bignum_t     r_pass_b;
   bignum_t     r_result;
   logic        r_busy;
   logic        r_done;
   logic        r_pass_en;
   logic [4:0]  r_pass_i;

   bignum_t          w_rot_src;
   logic [31:0][7:0] w_rot_blocks;
   logic [4:0]       w_next_i;
   logic [32:0]      w_u;
   logic             w_take;

   // The rearranged b is computed for the pass about to be issued: column 0
   // straight from the input port on acceptance, otherwise column i+1 from
   // the latched copy.
   assign w_rot_src = (r_state == S_IDLE) ? i_b_in : r_b;
   assign w_next_i  = (r_state == S_IDLE) ? 5'd0 : r_pass_i + 5'd1;

   // Limb j of column i takes b[(i - j) mod 32]; the 5-bit subtraction
   // provides the wrap for free.
   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_rot
         assign w_rot_blocks[gi] = w_rot_src.blocks[w_next_i - 5'(gi)];
      end
   endgenerate

   // Squeeze accumulator: previous carry plus the current column word.
   assign w_u = r_carry + {1'b0, r_w[r_sq_j]};

   // Column sums are only accepted while a multiply is outstanding, and
   // never more than 32 of them.
   assign w_take = i_pass_valid && !r_coll_cnt[5] &&
                   ((r_state == S_ISSUE) || (r_state == S_COLLECT));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_DRAIN;
         r_drain_cnt <= '0;
         r_coll_cnt  <= '0;
         r_sq_j      <= '0;
         r_carry     <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_pass_b    <= '0;
         r_result    <= '0;
         r_busy      <= 1'b1;
         r_done      <= 1'b0;
         r_pass_en   <= 1'b0;
         r_pass_i    <= '0;
         for (int k = 0; k < 32; k++) begin
            r_w[k] <= '0;
         end
      end else begin
         r_done <= 1'b0;

         if (w_take) begin
            r_w[r_coll_cnt[4:0]] <= i_pass_out;
            r_coll_cnt           <= r_coll_cnt + 6'd1;
         end

         case (r_state)
            // Let results issued before the reset flush out of the pipeline.
            S_DRAIN: begin
               if (r_drain_cnt == 8'(PASS_LATENCY - 1)) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_drain_cnt <= r_drain_cnt + 8'd1;
               end
            end

            S_IDLE: begin
               if (i_start) begin
                  r_a      <= i_a_in;
                  r_b      <= i_b_in;
                  r_coll_cnt     <= '0;
                  r_pass_en      <= 1'b1;
                  r_pass_i       <= 5'd0;
                  r_pass_b.blocks <= w_rot_blocks;
                  r_busy         <= 1'b1;
                  r_state        <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               if (r_pass_i == 5'd31) begin
                  r_pass_en <= 1'b0;
                  r_state   <= S_COLLECT;
               end else begin
                  r_pass_i        <= w_next_i;
                  r_pass_b.blocks <= w_rot_blocks;
               end
            end

            S_COLLECT: begin
               if ((w_take && (r_coll_cnt == 6'd31)) || r_coll_cnt[5]) begin
                  r_sq_j  <= '0;
                  r_carry <= '0;
                  r_state <= S_SQ1;
               end
            end

            // First round; the top limb keeps 7 bits and 2^255 folds back
            // into limb 0 as 19.
            S_SQ1: begin
               if (r_sq_j == 5'd31) begin
                  r_w[31] <= {25'd0, w_u[6:0]};
                  r_carry <= 33'd19 * (w_u >> 7);
                  r_sq_j  <= '0;
                  r_state <= S_SQ2;
               end else begin
                  r_w[r_sq_j] <= {24'd0, w_u[7:0]};
                  r_carry     <= w_u >> 8;
                  r_sq_j      <= r_sq_j + 5'd1;
               end
            end

            // Second round; the top limb absorbs the final carry unmasked.
            // The result is loaded on the last step so that it is visible
            // in the same cycle as the done pulse.
            S_SQ2: begin
               if (r_sq_j == 5'd31) begin
                  r_w[31] <= w_u[31:0];
                  for (int k = 0; k < 31; k++) begin
                     r_result.blocks[k] <= r_w[k][7:0];
                  end
                  r_result.blocks[31] <= w_u[7:0];
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end else begin
                  r_w[r_sq_j] <= {24'd0, w_u[7:0]};
                  r_carry     <= w_u >> 8;
                  r_sq_j      <= r_sq_j + 5'd1;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_result  = r_result;
   assign o_pass_en = r_pass_en;
   assign o_pass_i  = r_pass_i;
   assign o_pass_a  = r_a;
   assign o_pass_b  = r_pass_b;

endmodule

// File: tb/tb_x25519_mult_sequencer.sv
// ---------------------------------------------------------------------------
// tb_x25519_mult_sequencer
//
// Purpose:
//   Self-checking bench for x25519_mult_sequencer. A behavioural column-pass
//   pipeline with PASS_LATENCY cycles of delay answers the issued passes.
//   Products are checked against a whole-operand NaCl mult() model, and
//   directed cases are checked against known constants.
// ---------------------------------------------------------------------------
module tb_x25519_mult_sequencer;

   localparam int L       = 5;
   localparam int DONE_AT = 97 + L;

   typedef logic [31:0][7:0] limbs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   limbs_t      a_in;
   limbs_t      b_in;
   logic        busy;
   logic        done;
   limbs_t      result;
   logic        pass_en;
   logic [4:0]  pass_i;
   limbs_t      pass_a;
   limbs_t      pass_b;
   logic        pass_valid;
   logic [31:0] pass_out;

   int total = 0;
   int bad   = 0;

   logic        pipe_v [L];
   logic [31:0] pipe_d [L];
   logic        inject;
   logic [31:0] inject_data;

   x25519_mult_sequencer #(.PASS_LATENCY(L)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_a_in       (a_in),
      .i_b_in       (b_in),
      .o_busy       (busy),
      .o_done       (done),
      .o_result     (result),
      .o_pass_en    (pass_en),
      .o_pass_i     (pass_i),
      .o_pass_a     (pass_a),
      .o_pass_b     (pass_b),
      .i_pass_valid (pass_valid),
      .i_pass_out   (pass_out)
   );

   always #5 clk = ~clk;

   // Column pass: sum of a[j]*b'[j], wrapped terms (j > i) scaled by 38.
   function automatic logic [31:0] column_sum(input limbs_t pa, input limbs_t pb,
                                              input logic [4:0] i);
      longint unsigned s;
      s = 0;
      for (int j = 0; j < 32; j++) begin
         s += 64'(pa[j]) * 64'(pb[j]) * ((j > int'(i)) ? 64'd38 : 64'd1);
      end
      return s[31:0];
   endfunction

   // Downstream pass pipeline; it is deliberately not reset so that passes
   // in flight across a reset are still delivered.
   always @(posedge clk) begin
      pipe_v[0] <= pass_en;
      pipe_d[0] <= column_sum(pass_a, pass_b, pass_i);
      for (int k = 1; k < L; k++) begin
         pipe_v[k] <= pipe_v[k-1];
         pipe_d[k] <= pipe_d[k-1];
      end
   end

   assign pass_valid = pipe_v[L-1] | inject;
   assign pass_out   = inject ? inject_data : pipe_d[L-1];

   function automatic limbs_t rand_limbs();
      logic [255:0] t;
      for (int k = 0; k < 8; k++) begin
         t[32*k +: 32] = $urandom();
      end
      return t;
   endfunction

   // NaCl mult(): schoolbook columns with 2^256 = 38, then one squeeze.
   function automatic limbs_t ref_mult(input limbs_t a, input limbs_t b);
      longint unsigned w [32];
      longint unsigned u;
      limbs_t r;
      for (int i = 0; i < 32; i++) begin
         u = 0;
         for (int j = 0; j < 32; j++) begin
            if (j <= i) u += 64'(a[j]) * 64'(b[i-j]);
            else        u += 64'd38 * 64'(a[j]) * 64'(b[i+32-j]);
         end
         w[i] = u;
      end
      u = 0;
      for (int rnd = 0; rnd < 2; rnd++) begin
         for (int j = 0; j < 31; j++) begin
            u += w[j];
            w[j] = u & 64'd255;
            u = u >> 8;
         end
         u += w[31];
         if (rnd == 0) begin
            w[31] = u & 64'd127;
            u = 64'd19 * (u >> 7);
         end else begin
            w[31] = u;
         end
      end
      for (int j = 0; j < 32; j++) begin
         r[j] = w[j][7:0];
      end
      return r;
   endfunction

   // Runs one multiply; reports done cycle (relative to the start cycle),
   // pass_en count, pass_i ordering, result stability and the result.
   task automatic run_op(input limbs_t a, input limbs_t b, input bit noise,
                         output int done_cyc, output int en_cnt, output bit i_ok,
                         output bit res_stable, output limbs_t res);
      limbs_t prev;
      int exp_i;
      prev       = result;
      exp_i      = 0;
      done_cyc   = -1;
      en_cnt     = 0;
      i_ok       = 1'b1;
      res_stable = 1'b1;
      res        = '0;
      @(negedge clk);
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (noise && cyc > 1 && cyc < 95 && $urandom_range(0, 3) == 0) begin
            start = 1'b1;
            a_in  = rand_limbs();
            b_in  = rand_limbs();
         end
         if (pass_en) begin
            if (pass_i !== 5'(exp_i)) i_ok = 1'b0;
            exp_i++;
            en_cnt++;
         end
         if (done) begin
            done_cyc = cyc;
            res      = result;
            break;
         end
         if (result !== prev) res_stable = 1'b0;
      end
      start = 1'b0;
      $display("txn a=%h b=%h result=%h done_at=%0d passes=%0d", a, b, res, done_cyc, en_cnt);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
      inject = 1'b0; inject_data = '0;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (pass_en !== 1'b0) begin bad++; $display("FAIL reset_pass_en: got %b want 0", pass_en); end
      total++; if (pass_i !== 5'd0) begin bad++; $display("FAIL reset_pass_i: got %0d want 0", pass_i); end
      total++; if (result !== '0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
      rst = 1'b0;
      for (int k = 0; k <= L; k++) begin
         total++;
         if (busy !== (k < L)) begin
            bad++; $display("FAIL reset_drain_busy k=%0d: got %b want %b", k, busy, (k < L));
         end
         if (k < L) @(negedge clk);
      end
   endtask

   task automatic test_unit();
      int dc, ec; bit iok, rs; limbs_t r, one;
      one = '0; one[0] = 8'd1;
      run_op(one, one, 1'b0, dc, ec, iok, rs, r);
      total++; if (dc != DONE_AT) begin bad++; $display("FAIL unit_done_cycle: got %0d want %0d", dc, DONE_AT); end
      total++; if (ec != 32) begin bad++; $display("FAIL unit_pass_count: got %0d want 32", ec); end
      total++; if (iok !== 1'b1) begin bad++; $display("FAIL unit_pass_i_order: got %b want 1", iok); end
      total++; if (rs !== 1'b1) begin bad++; $display("FAIL unit_result_stable: got %b want 1", rs); end
      total++; if (r !== one) begin bad++; $display("FAIL unit_result: got %h want %h", r, one); end
   endtask

   task automatic test_directed();
      int dc, ec; bit iok, rs; limbs_t a, b, r, exp;
      // 255 * 255 = 0xFE01
      a = '0; b = '0; a[0] = 8'd255; b[0] = 8'd255;
      exp = '0; exp[0] = 8'h01; exp[1] = 8'hFE;
      run_op(a, b, 1'b0, dc, ec, iok, rs, r);
      total++; if (r !== exp) begin bad++; $display("FAIL byte_carry: got %h want %h", r, exp); end
      // 2^248 * 2^8 = 2^256 = 38
      a = '0; b = '0; a[31] = 8'd1; b[1] = 8'd1;
      exp = '0; exp[0] = 8'd38;
      run_op(a, b, 1'b0, dc, ec, iok, rs, r);
      total++; if (r !== exp) begin bad++; $display("FAIL wrap38: got %h want %h", r, exp); end
      // 2^255 = 19
      a = '0; b = '0; a[31] = 8'd128; b[0] = 8'd1;
      exp = '0; exp[0] = 8'd19;
      run_op(a, b, 1'b0, dc, ec, iok, rs, r);
      total++; if (r !== exp) begin bad++; $display("FAIL fold19: got %h want %h", r, exp); end
      total++; if (dc != DONE_AT) begin bad++; $display("FAIL fold19_done_cycle: got %0d want %0d", dc, DONE_AT); end
   endtask

   task automatic test_random();
      int dc, ec; bit iok, rs; limbs_t a, b, r, exp;
      for (int n = 0; n < 200; n++) begin
         if (n == 0) begin
            a = '1; b = '1;
         end else begin
            a = rand_limbs(); b = rand_limbs();
         end
         exp = ref_mult(a, b);
         run_op(a, b, 1'b1, dc, ec, iok, rs, r);
         total++; if (r !== exp) begin bad++; $display("FAIL rand_result n=%0d: got %h want %h", n, r, exp); end
         total++; if (ec != 32) begin bad++; $display("FAIL rand_pass_count n=%0d: got %0d want 32", n, ec); end
         total++; if (rs !== 1'b1) begin bad++; $display("FAIL rand_result_stable n=%0d: got %b want 1", n, rs); end
         total++; if (dc != DONE_AT) begin bad++; $display("FAIL rand_done_cycle n=%0d: got %0d want %0d", n, dc, DONE_AT); end
      end
   endtask

   task automatic test_reset_abort();
      int dc, ec; bit iok, rs, seen, done_seen, en_seen; limbs_t r, one;
      seen = 1'b0; done_seen = 1'b0; en_seen = 1'b0;
      @(negedge clk);
      start = 1'b1; a_in = rand_limbs(); b_in = rand_limbs();
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (pass_en && pass_i == 5'd10) begin
            seen = 1'b1;
            break;
         end
      end
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL abort_reach_i10: got %b want 1", seen); end
      rst = 1'b1;
      #1;
      total++; if (pass_en !== 1'b0) begin bad++; $display("FAIL abort_pass_en_async: got %b want 0", pass_en); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < L; k++) begin
         inject = 1'b1;
         inject_data = $urandom();
         start = (k == 1);
         if (k == 1) begin a_in = rand_limbs(); b_in = rand_limbs(); end
         total++;
         if (busy !== 1'b1) begin bad++; $display("FAIL abort_drain_busy k=%0d: got %b want 1", k, busy); end
         @(negedge clk);
      end
      inject = 1'b0;
      start  = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_drain_end_busy: got %b want 0", busy); end
      for (int c = 0; c < 150; c++) begin
         @(negedge clk);
         if (done) done_seen = 1'b1;
         if (pass_en) en_seen = 1'b1;
      end
      total++; if (done_seen !== 1'b0) begin bad++; $display("FAIL abort_no_done: got %b want 0", done_seen); end
      total++; if (en_seen !== 1'b0) begin bad++; $display("FAIL abort_start_in_drain: got %b want 0", en_seen); end
      one = '0; one[0] = 8'd1;
      run_op(one, one, 1'b0, dc, ec, iok, rs, r);
      total++; if (r !== one) begin bad++; $display("FAIL abort_next_result: got %h want %h", r, one); end
      total++; if (dc != DONE_AT) begin bad++; $display("FAIL abort_next_done_cycle: got %0d want %0d", dc, DONE_AT); end
   endtask

   initial begin
      test_reset();
      test_unit();
      test_directed();
      test_random();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
